// File: rtl/tsu_queue_arb.sv
// tsu_queue_arb: drains up to four TSU time-stamp queues into one 48-bit
// valid/ready record stream, and sequences per-queue flushes on request.
// Runs entirely in the queue read-clock domain.
// Build option: define TSU_QUEUE_ARB_PRIO_EN for fixed-priority arbitration
// (lowest eligible index wins, no round-robin pointer); default is round-robin.
module tsu_queue_arb #(
  parameter int NQ        = 2,
  parameter int RD_LAT    = 1,
  parameter int FLUSH_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [8*NQ-1:0]   q_rd_stat,
  input  logic [48*NQ-1:0]  q_rd_data,
  output logic [NQ-1:0]     q_rd_en,
  output logic [NQ-1:0]     q_rst,
  input  logic [NQ-1:0]     flush_req,
  output logic [NQ-1:0]     flush_busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [47:0]       out_data,
  output logic [1:0]        out_src
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CAPT  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_FLUSH = 3'd5;

  logic [2:0]      state;
  logic [1:0]      grant;
  logic [1:0]      fidx;
  logic [NQ-1:0]   pend;
  logic [NQ-1:0]   pend_clr;
  logic [3:0]      fcnt;
  logic [1:0]      wcnt;
  logic [NQ-1:0]   elig;
  logic [4*NQ-1:0] stat_hi;
  logic [47:0]     rd_sel;
  logic [1:0]      arb_start;
  logic [1:0]      arb_pick;
  logic [1:0]      flush_pick;
  logic            flush_done;
  logic            unused_stat_hi;

  // First set bit of req at or after start, wrapping modulo NQ.
  function automatic logic [1:0] pick_from(input logic [NQ-1:0] req,
                                           input logic [1:0]    start);
    logic [1:0] res;
    logic       found;
    int         idx;
    res   = start;
    found = 1'b0;
    for (int k = 0; k < NQ; k++) begin
      idx = (int'(start) + k) % NQ;
      if (!found && req[idx]) begin
        res   = 2'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Eligibility, read-data select and strobe/reset decode from FSM state.
  always_comb begin
    elig     = '0;
    stat_hi  = '0;
    rd_sel   = '0;
    q_rd_en  = '0;
    q_rst    = '0;
    pend_clr = '0;
    for (int i = 0; i < NQ; i++) begin
      elig[i]          = (q_rd_stat[8*i +: 4] != 4'd0) && !pend[i];
      stat_hi[4*i +: 4] = q_rd_stat[8*i+4 +: 4];
      if (grant == 2'(i)) rd_sel = q_rd_data[48*i +: 48];
      q_rd_en[i]  = (state == S_ISSUE) && (grant == 2'(i));
      q_rst[i]    = (state == S_FLUSH) && (fidx == 2'(i));
      pend_clr[i] = flush_done && (fidx == 2'(i));
    end
  end

  assign unused_stat_hi = ^stat_hi;
  assign flush_done     = (state == S_FLUSH) && (fcnt == 4'(FLUSH_CYC - 1));
  assign flush_busy     = pend;
  assign flush_pick     = pick_from(pend, 2'd0);
  assign arb_pick       = pick_from(elig, arb_start);

`ifdef TSU_QUEUE_ARB_PRIO_EN
  assign arb_start = 2'd0;
`else
  logic [1:0] rr_ptr;

  function automatic logic [1:0] next_idx(input logic [1:0] g);
    if (int'(g) + 1 >= NQ) return 2'd0;
    return g + 2'd1;
  endfunction

  assign arb_start = rr_ptr;

  // Round-robin pointer advances past each queue as its record is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                rr_ptr <= 2'd0;
    else if (state == S_CAPT)  rr_ptr <= next_idx(grant);
  end
`endif

  // Sticky flush-pending bits; a level request still high on exit re-arms.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= (pend & ~pend_clr) | flush_req;
  end

  // Main sequencer: flush beats read, read strobe, latency wait, capture, hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      grant     <= 2'd0;
      fidx      <= 2'd0;
      fcnt      <= 4'd0;
      wcnt      <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|pend) begin
            fidx  <= flush_pick;
            fcnt  <= 4'd0;
            state <= S_FLUSH;
          end else if (|elig) begin
            grant <= arb_pick;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wcnt  <= 2'd0;
          state <= (RD_LAT > 1) ? S_WAIT : S_CAPT;
        end
        S_WAIT: begin
          if (wcnt == 2'(RD_LAT - 2)) state <= S_CAPT;
          else                        wcnt  <= wcnt + 2'd1;
        end
        S_CAPT: begin
          out_data  <= rd_sel;
          out_src   <= grant;
          out_valid <= 1'b1;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        S_FLUSH: begin
          if (flush_done) state <= S_IDLE;
          else            fcnt  <= fcnt + 4'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tsu_queue_arb.sv
`timescale 1ns/1ps
module tb_tsu_queue_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Instance A: NQ=2, RD_LAT=1
  logic [15:0] stat_a;
  logic [95:0] data_a;
  logic [1:0]  rd_en_a, qrst_a, fbusy_a, freq_a, osrc_a;
  logic        oval_a, ordy_a;
  logic [47:0] odata_a;

  // Instance B: NQ=2, RD_LAT=3
  logic [15:0] stat_b;
  logic [95:0] data_b;
  logic [1:0]  rd_en_b, qrst_b, fbusy_b, freq_b, osrc_b;
  logic        oval_b, ordy_b;
  logic [47:0] odata_b;

  tsu_queue_arb #(.NQ(2), .RD_LAT(1), .FLUSH_CYC(4)) u_a (
    .clk(clk), .rst_n(rst_n), .q_rd_stat(stat_a), .q_rd_data(data_a),
    .q_rd_en(rd_en_a), .q_rst(qrst_a), .flush_req(freq_a), .flush_busy(fbusy_a),
    .out_valid(oval_a), .out_ready(ordy_a), .out_data(odata_a), .out_src(osrc_a));

  tsu_queue_arb #(.NQ(2), .RD_LAT(3), .FLUSH_CYC(4)) u_b (
    .clk(clk), .rst_n(rst_n), .q_rd_stat(stat_b), .q_rd_data(data_b),
    .q_rd_en(rd_en_b), .q_rst(qrst_b), .flush_req(freq_b), .flush_busy(fbusy_b),
    .out_valid(oval_b), .out_ready(ordy_b), .out_data(odata_b), .out_src(osrc_b));

  // Queue model for instance A (upper status nibble deliberately nonzero).
  logic [3:0]  cnt   [2];
  logic [47:0] base  [2];
  logic [47:0] dreg  [2];
  int          rd_idx[2];
  int          ocnt  [2];
  int          nreads;
  int          checks;
  int          failures;

  assign stat_a = {4'hF, cnt[1], 4'hF, cnt[0]};
  assign data_a = {dreg[1], dreg[0]};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic [1:0] en;
    en = rd_en_a;
    @(posedge clk);
    #1;
    for (int q = 0; q < 2; q++) begin
      if (en[q]) begin
        dreg[q] = base[q] + 48'(rd_idx[q]);
        rd_idx[q]++;
        cnt[q] = cnt[q] - 4'd1;
        nreads++;
      end
    end
  endtask

  task automatic setq(input int q, input logic [3:0] n, input logic [47:0] b);
    cnt[q]    = n;
    base[q]   = b;
    rd_idx[q] = 0;
    ocnt[q]   = 0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    for (int n = 0; n < budget && !oval_a; n++) tick();
    chk(tag, oval_a, 1'b1);
  endtask

  // Collect n transfers; exp_order holds 2-bit sources, first record in [1:0].
  task automatic collect(input string tag, input int n, input logic [11:0] exp_order);
    int got;
    logic [1:0] s;
    got = 0;
    for (int c = 0; c < 200 && got < n; c++) begin
      if (oval_a && ordy_a) begin
        s = exp_order[2*got +: 2];
        chk({tag, "_src"}, osrc_a, s);
        chk({tag, "_data"}, odata_a, base[s] + 48'(ocnt[s]));
        ocnt[s]++;
        got++;
      end
      tick();
    end
    chk({tag, "_count"}, got, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int rst_cyc, bad;
    logic busy_ok, busy_after;
    checks = 0; failures = 0; nreads = 0;
    rst_n = 1'b0; freq_a = '0; ordy_a = 1'b1;
    stat_b = '0; data_b = '0; freq_b = '0; ordy_b = 1'b1;
    for (int q = 0; q < 2; q++) begin
      setq(q, 4'd0, 48'd0);
      dreg[q] = 48'd0;
    end
    repeat (3) tick();

    // Reset state
    chk("rst_rd_en", rd_en_a, 2'b00);
    chk("rst_q_rst", qrst_a, 2'b00);
    chk("rst_busy", fbusy_a, 2'b00);
    chk("rst_valid", oval_a, 1'b0);
    chk("rst_data", odata_a, 48'd0);
    chk("rst_src", osrc_a, 2'd0);
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_hi_nibble_ignored", rd_en_a, 2'b00);

    // Single read, RD_LAT=1
    setq(0, 4'd1, 48'h0000_1234_5678);
    tick(); chk("t1_issue", rd_en_a, 2'b01);
    tick(); chk("t1_capt_rd", rd_en_a, 2'b00); chk("t1_capt_vld", oval_a, 1'b0);
    tick(); chk("t1_vld", oval_a, 1'b1);
    chk("t1_data", odata_a, 48'h0000_1234_5678);
    chk("t1_src", osrc_a, 2'd0);
    tick(); chk("t1_drop", oval_a, 1'b0);
    tick(); tick(); chk("t1_one_read", nreads, 1);

    // Round-robin (fresh pointer)
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    setq(0, 4'd3, 48'h0000_AAAA_0000);
    setq(1, 4'd3, 48'h0000_BBBB_0000);
`ifdef TSU_QUEUE_ARB_PRIO_EN
    collect("prio", 6, 12'b01_01_01_00_00_00);
`else
    collect("rr", 6, 12'b01_00_01_00_01_00);
`endif
    tick(); tick();
    chk("rr_reads", nreads, 7);

    // Backpressure
    ordy_a = 1'b0;
    setq(0, 4'd2, 48'h0000_CCCC_0000);
    wait_valid("bp_wait", 20);
    chk("bp_src", osrc_a, 2'd0);
    chk("bp_data", odata_a, 48'h0000_CCCC_0000);
    bad = 0;
    repeat (10) begin
      tick();
      if (oval_a !== 1'b1 || odata_a !== 48'h0000_CCCC_0000 || osrc_a !== 2'd0 || rd_en_a !== 2'b00)
        bad++;
    end
    chk("bp_stable_no_rd", bad, 0);
    ordy_a = 1'b1;
    tick(); ocnt[0]++;
    chk("bp_one_xfer", oval_a, 1'b0);
    collect("bp_next", 1, 12'b00);

    // Flush during HOLD
    ordy_a = 1'b0;
    setq(1, 4'd1, 48'h0000_DDDD_0000);
    wait_valid("fl_wait", 20);
    chk("fl_hold_src", osrc_a, 2'd1);
    chk("fl_hold_data", odata_a, 48'h0000_DDDD_0000);
    freq_a = 2'b10; tick(); freq_a = 2'b00;
    chk("fl_busy_hold", fbusy_a, 2'b10);
    chk("fl_no_rst_hold", qrst_a, 2'b00);
    setq(0, 4'd2, 48'h0000_EEEE_0000);
    tick();
    chk("fl_still_valid", oval_a, 1'b1);
    ordy_a = 1'b1;
    tick(); ocnt[1]++;
    chk("fl_xfer_first", oval_a, 1'b0);
    rst_cyc = 0; bad = 0; busy_ok = 1'b1; busy_after = 1'b1;
    for (int n = 0; n < 20 && rd_en_a == 2'b00; n++) begin
      tick();
      if (qrst_a == 2'b10) begin
        rst_cyc++;
        if (fbusy_a[1] !== 1'b1) busy_ok = 1'b0;
      end else if (qrst_a != 2'b00) begin
        bad++;
      end else if (rst_cyc > 0 && rd_en_a == 2'b00) begin
        busy_after = fbusy_a[1];
      end
    end
    chk("fl_rst_cycles", rst_cyc, 4);
    chk("fl_busy_during", busy_ok, 1'b1);
    chk("fl_busy_cleared", busy_after, 1'b0);
    chk("fl_q0_untouched", bad, 0);
    chk("fl_q0_after", rd_en_a, 2'b01);
    collect("fl_q0", 2, 12'b0000);

    // RD_LAT=3 capture timing
    stat_b = 16'h0001;
    tick(); chk("l3_issue", rd_en_b, 2'b01);
    stat_b = 16'h0000; data_b[47:0] = 48'hBAD0_0000_0000;
    tick(); chk("l3_wait_rd", rd_en_b, 2'b00); data_b[47:0] = 48'hBAD1_0000_0001;
    tick(); data_b[47:0] = 48'hBAD2_0000_0002;
    tick(); chk("l3_capt_vld", oval_b, 1'b0); data_b[47:0] = 48'h0000_ABCD_0003;
    tick(); data_b[47:0] = 48'hBAD4_0000_0004;
    chk("l3_vld", oval_b, 1'b1);
    chk("l3_data", odata_b, 48'h0000_ABCD_0003);
    chk("l3_src", osrc_b, 2'd0);
    tick(); chk("l3_drop", oval_b, 1'b0);

    // Async reset while B is in WAIT and A is in FLUSH
    stat_b = 16'h0101; freq_a = 2'b01;
    tick();
`ifdef TSU_QUEUE_ARB_PRIO_EN
    chk("ar_issue", rd_en_b, 2'b01);
`else
    chk("ar_issue", rd_en_b, 2'b10);
`endif
    chk("ar_busy", fbusy_a, 2'b01);
    freq_a = 2'b00;
    tick();
    chk("ar_wait_rd", rd_en_b, 2'b00);
    chk("ar_flush_rst", qrst_a, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_q_rst", qrst_a, 2'b00);
    chk("ar_busy0", fbusy_a, 2'b00);
    chk("ar_rd_en", rd_en_b, 2'b00);
    chk("ar_valid", oval_b, 1'b0);
    chk("ar_data", odata_b, 48'd0);
    tick(); rst_n = 1'b1;
    tick();
    chk("ar_next_q0", rd_en_b, 2'b01);
    chk("ar_no_flush", qrst_a, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
